// File: rtl/otter_div_pkg.sv
// Shared types and constants for the OTTER iterative divider.
package otter_div_pkg;

  localparam int unsigned DIV_XLEN = 32;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_t;

  localparam logic [DIV_XLEN-1:0] DIV_BY_ZERO_Q = '1;
  localparam logic [DIV_XLEN-1:0] SIGNED_MIN    = {1'b1, {(DIV_XLEN-1){1'b0}}};

endpackage

// File: rtl/otter_div_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left, trial-subtract divisor.
module otter_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    diff    = shifted - {1'b0, div_i};
    // rem < div holds on entry, so a non-negative diff always fits in XLEN bits
    if (!diff[XLEN]) begin
      rem_o = diff[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = {rem_i[XLEN-2:0], quo_i[XLEN-1]};
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/otter_div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit, one quotient bit per clock,
// START/BUSY/DONE handshake with KILL squash.
module otter_div_unit
  import otter_div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic            KILL,
  input  logic [1:0]      FUNCT3,
  input  logic [XLEN-1:0] OP1,
  input  logic [XLEN-1:0] OP2,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  localparam int CW = $clog2(XLEN) + 1;

  div_state_t      state_q;
  div_op_t         op_q;
  logic [XLEN-1:0] div_q, rem_q, quo_q, res_q;
  logic [XLEN-1:0] rem_d, quo_d;
  logic            negq_q, negr_q, busy_q, done_q;
  logic [CW-1:0]   cnt_q;

  logic            is_signed, is_rem, op1_neg, op2_neg, div0, ovf;
  logic [XLEN-1:0] abs1, abs2, spec_res, q_fix, r_fix, fix_res;

  always_comb begin
    is_signed = ~FUNCT3[0];
    is_rem    = FUNCT3[1];
    op1_neg   = is_signed & OP1[XLEN-1];
    op2_neg   = is_signed & OP2[XLEN-1];
    abs1      = op1_neg ? (~OP1 + 1'b1) : OP1;
    abs2      = op2_neg ? (~OP2 + 1'b1) : OP2;
    div0      = (OP2 == '0);
    ovf       = is_signed && (OP1 == SIGNED_MIN) && (OP2 == DIV_BY_ZERO_Q);
    if (div0) spec_res = is_rem ? OP1 : DIV_BY_ZERO_Q;
    else      spec_res = is_rem ? '0  : SIGNED_MIN;
  end

  otter_div_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (div_q),
    .rem_o (rem_d),
    .quo_o (quo_d)
  );

  always_comb begin
    q_fix   = negq_q ? (~quo_q + 1'b1) : quo_q;
    r_fix   = negr_q ? (~rem_q + 1'b1) : rem_q;
    fix_res = (op_q == OP_REM || op_q == OP_REMU) ? r_fix : q_fix;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      op_q    <= OP_DIV;
      div_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      res_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (KILL) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, otter_div_pkg::DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (START) begin
            if (div0 || ovf) begin
              // architecturally defined results bypass the iteration entirely
              res_q   <= spec_res;
              done_q  <= 1'b1;
              state_q <= otter_div_pkg::DONE;
            end else begin
              op_q    <= div_op_t'(FUNCT3);
              div_q   <= abs2;
              quo_q   <= abs1;
              rem_q   <= '0;
              cnt_q   <= '0;
              negq_q  <= op1_neg ^ op2_neg;
              negr_q  <= op1_neg;
              busy_q  <= 1'b1;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN - 1)) state_q <= FIX;
        end
        FIX: begin
          res_q   <= fix_res;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= otter_div_pkg::DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = res_q;

endmodule

// File: tb/tb_otter_div_unit.sv
// Directed-vector bench for otter_div_unit: latency, results, special cases, KILL, reset.
module tb_otter_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [1:0]  funct3;
  logic [31:0] op1, op2, result;
  logic        busy, done;

  int tot = 0;
  int bad = 0;

  otter_div_unit dut (
    .CLK    (clk),
    .RST    (rst),
    .START  (start),
    .KILL   (kill),
    .FUNCT3 (funct3),
    .OP1    (op1),
    .OP2    (op2),
    .BUSY   (busy),
    .DONE   (done),
    .RESULT (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after edge 0.
  task automatic launch(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; funct3 = f; op1 = a; op2 = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; funct3 = 2'($urandom); op1 = $urandom; op2 = $urandom;
  endtask

  // n counts edges after edge 0; stops at the first negedge that sees DONE.
  task automatic wait_done(input int n0, input int lat, output int n, output int berr);
    n = n0; berr = 0;
    while (!done && n < 60) begin
      if (busy !== (n < lat)) berr++;
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) berr++;
  endtask

  task automatic run_op(input string tag, input logic [1:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n, berr;
    launch(f, a, b);
    wait_done(0, lat, n, berr);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_busy"}, berr, 0);
    chk({tag, "_res"}, result, exp);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'b0, done}, 0);
  endtask

  initial begin
    int n, berr, dcnt;
    rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 2'b00; op1 = '0; op2 = '0;
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_res", result, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("divu", 2'b01, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu", 2'b11, 32'd100, 32'd7, 32'd2, 33);
    run_op("div_n7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem_n7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("div_7_n2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("div_zero_dvd", 2'b00, 32'd0, 32'd9, 32'd0, 33);
    run_op("divu_by0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("rem_by0", 2'b10, 32'd5, 32'd0, 32'd5, 0);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);

    // KILL at edge 10: RESULT must keep the overflow result from above
    launch(2'b01, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    kill = 1'b1; start = 1'b1;
    @(negedge clk);
    kill = 1'b0; start = 1'b0;
    chk("kill_busy", {31'b0, busy}, 0);
    dcnt = 0;
    repeat (40) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    chk("kill_nodone", dcnt, 0);
    chk("kill_res", result, 32'h8000_0000);
    run_op("after_kill", 2'b01, 32'd1000, 32'd3, 32'd333, 33);

    // START during CALC is ignored
    launch(2'b01, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    start = 1'b1; funct3 = 2'b11; op1 = 32'd50; op2 = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, 33, n, berr);
    chk("ign_lat", n, 33);
    chk("ign_busy", berr, 0);
    chk("ign_res", result, 32'd14);

    // back-to-back start from the DONE cycle
    start = 1'b1; funct3 = 2'b01; op1 = 32'd1000; op2 = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_drop", {31'b0, done}, 0);
    chk("b2b_busy", {31'b0, busy}, 1);
    wait_done(0, 33, n, berr);
    chk("b2b_lat", n + 1, 34);
    chk("b2b_res", result, 32'd333);
    @(negedge clk);

    // async reset between edges, mid-CALC
    launch(2'b01, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_done", {31'b0, done}, 0);
    chk("arst_res", result, 0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    repeat (40) begin
      if (done || busy) dcnt++;
      @(negedge clk);
    end
    chk("arst_idle", dcnt, 0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
